// File: rtl/gap_stream_tx.sv
// gap_stream_tx: global-average-pooling transmitter; per-channel sums of one frame streamed out as means.
// Optional `GAP_ROUND_EN` selects round-half-away-from-zero instead of floor division.
module gap_stream_tx #(
  parameter int C_CH    = 64,
  parameter int HW_LOG2 = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 25,
  parameter int ACC_W   = IN_W + HW_LOG2 + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_W-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic [$clog2(C_CH)-1:0]    out_index,
  output logic                       out_last,
  output logic                       frame_done
);
  localparam int CW = $clog2(C_CH);
  localparam logic [CW-1:0] CH_LAST = CW'(C_CH - 1);
  localparam logic [HW_LOG2-1:0] PIX_LAST = '1;
`ifdef GAP_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (HW_LOG2 - 1));
`endif

  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state;
  logic signed [ACC_W-1:0] acc [C_CH];
  logic [CW-1:0] ch_cnt, emit_cnt, emit_nxt;
  logic [HW_LOG2-1:0] pix_cnt;
  logic signed [ACC_W-1:0] in_ext, sum_new;
  logic in_fire, out_fire, last_in;

  function automatic logic signed [ACC_W-1:0] div(input logic signed [ACC_W-1:0] x);
`ifdef GAP_ROUND_EN
    return x[ACC_W-1] ? -((-x + HALF) >>> HW_LOG2) : (x + HALF) >>> HW_LOG2;
`else
    return x >>> HW_LOG2;
`endif
  endfunction

  always_comb begin
    in_ext   = ACC_W'(in_data);
    sum_new  = acc[ch_cnt] + in_ext;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_in  = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
    emit_nxt = emit_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      ch_cnt     <= '0;
      pix_cnt    <= '0;
      emit_cnt   <= '0;
      for (int i = 0; i < C_CH; i++) acc[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == ACCUM) begin
        in_ready <= !(in_fire && last_in);
        if (in_fire) begin
          acc[ch_cnt] <= sum_new;
          ch_cnt      <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
          if (ch_cnt == CH_LAST) pix_cnt <= pix_cnt + 1'b1;
          if (last_in) begin
            // element 0 is preloaded so out_valid rises the cycle after the last input
            state     <= EMIT;
            out_valid <= 1'b1;
            out_index <= '0;
            out_last  <= (C_CH == 1);
            out_data  <= OUT_W'(div((C_CH == 1) ? sum_new : acc[0]));
          end
        end
      end else if (out_fire) begin
        acc[emit_cnt] <= '0;
        emit_cnt      <= emit_nxt;
        out_index     <= emit_nxt;
        out_last      <= (emit_nxt == CH_LAST);
        out_data      <= OUT_W'(div(acc[emit_nxt]));
        if (out_last) begin
          state      <= ACCUM;
          out_valid  <= 1'b0;
          in_ready   <= 1'b1;
          frame_done <= 1'b1;
          emit_cnt   <= '0;
          out_index  <= '0;
          out_last   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gap_stream_tx.sv
// tb_gap_stream_tx: directed scenarios for gap_stream_tx with hand-derived expected means.
module tb_gap_stream_tx;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic signed [7:0] in_data = '0;
  logic out_valid;
  logic out_ready = 0;
  logic signed [24:0] out_data;
  logic [5:0] out_index;
  logic out_last;
  logic frame_done;

  int checks = 0;
  int errs = 0;
  int fd [1024];
  int ex [64];

  gap_stream_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int mean16(input int s);
`ifdef GAP_ROUND_EN
    return (s >= 0) ? (s + 8) / 16 : -((-s + 8) / 16);
`else
    return (s >= 0) ? s / 16 : -((-s + 15) / 16);
`endif
  endfunction

  task automatic push(input int v, input bit gaps);
    bit hs;
    int t = 0;
    if (gaps) begin
      in_valid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1;
    in_data = 8'(v);
    do begin
      hs = in_ready;
      @(negedge clk);
      t++;
    end while (!hs && t < 100);
    if (!hs) begin
      checks++; errs++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required handshake", t);
    end
  endtask

  task automatic collect(input bit bp);
    int k = 0, cyc = 0, stall = 0;
    bit ph = 0, held = 0;
    logic [24:0] hd;
    logic [5:0] hi;
    while (k < 64 && cyc < 3000) begin
      if (bp && k == 3 && stall < 10) begin out_ready = 0; stall++; end
      else if (bp && stall >= 10) begin out_ready = ph; ph = !ph; end
      else out_ready = 1;
      checks++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL in_ready_emit: got %b required 0 at k=%0d", in_ready, k); end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi) begin
          errs++;
          $display("FAIL hold_stable: got v=%b d=%h i=%0d required v=1 d=%h i=%0d", out_valid, out_data, out_index, hd, hi);
        end
      end
      if (!bp) begin
        checks++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL stream_gap: out_valid=%b required 1 at k=%0d", out_valid, k); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_index !== 6'(k) || out_data !== 25'(ex[k]) || out_last !== (k == 63)) begin
          errs++;
          $display("FAIL element: got i=%0d d=%h last=%b required i=%0d d=%h last=%b", out_index, out_data, out_last, k, 25'(ex[k]), k == 63);
        end
        k++;
      end
      held = (out_valid === 1'b1) && !out_ready;
      hd = out_data;
      hi = out_index;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    checks++;
    if (k < 64) begin errs++; $display("FAIL emit_timeout: got %0d elements required 64", k); end
    checks++;
    if (frame_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL frame_done_pulse: got fd=%b ov=%b ir=%b required 1 0 1", frame_done, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin errs++; $display("FAIL frame_done_width: got %b required 0", frame_done); end
  endtask

  task automatic run_frame(input bit gaps, input bit bp);
    for (int n = 0; n < 1024; n++) push(fd[n], gaps);
    collect(bp);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 0 || out_valid !== 0 || out_data !== 0 || out_index !== 0 || out_last !== 0 || frame_done !== 0) begin
      errs++;
      $display("FAIL reset_state: got ir=%b ov=%b d=%h i=%0d l=%b fd=%b required all 0", in_ready, out_valid, out_data, out_index, out_last, frame_done);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
  endtask

  task automatic test_constant;
    for (int n = 0; n < 1024; n++) fd[n] = 5;
    for (int c = 0; c < 64; c++) ex[c] = 5;
    run_frame(0, 0);
  endtask

  task automatic test_rounding;
    for (int n = 0; n < 1024; n++) begin
      case (n % 64)
        0: fd[n] = ((n / 64) % 2 == 0) ? 2 : 1;
        1: fd[n] = ((n / 64) < 8) ? 1 : 0;
        2: fd[n] = ((n / 64) < 7) ? -1 : 0;
        3: fd[n] = ((n / 64) < 8) ? -3 : -2;
        default: fd[n] = 0;
      endcase
    end
    for (int c = 0; c < 64; c++) ex[c] = 0;
`ifdef GAP_ROUND_EN
    ex[0] = 2; ex[1] = 1; ex[2] = 0; ex[3] = -3;
`else
    ex[0] = 1; ex[1] = 0; ex[2] = -1; ex[3] = -3;
`endif
    run_frame(0, 0);
  endtask

  task automatic test_extremes;
    for (int n = 0; n < 1024; n++) fd[n] = -128;
    for (int c = 0; c < 64; c++) ex[c] = -128;
    run_frame(0, 0);
    for (int n = 0; n < 1024; n++) fd[n] = 127;
    for (int c = 0; c < 64; c++) ex[c] = 127;
    run_frame(0, 0);
  endtask

  task automatic test_backpressure;
    for (int n = 0; n < 1024; n++) fd[n] = (n % 64) - 32;
    for (int c = 0; c < 64; c++) ex[c] = c - 32;
    run_frame(0, 1);
  endtask

  task automatic test_gaps;
    int s [64];
    for (int c = 0; c < 64; c++) s[c] = 0;
    for (int n = 0; n < 1024; n++) begin
      fd[n] = int'($urandom_range(0, 255)) - 128;
      s[n % 64] += fd[n];
    end
    for (int c = 0; c < 64; c++) ex[c] = mean16(s[c]);
    run_frame(1, 0);
  endtask

  task automatic test_reset_mid;
    for (int n = 0; n < 500; n++) push(3, 0);
    rst = 1;
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_state: got ir=%b ov=%b required 0 0", in_ready, out_valid);
    end
    for (int n = 0; n < 1024; n++) fd[n] = 9;
    for (int c = 0; c < 64; c++) ex[c] = 9;
    run_frame(0, 0);
  endtask

  initial begin
    test_reset;
    test_constant;
    test_rounding;
    test_extremes;
    test_backpressure;
    test_gaps;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
